cam_pos_to_pixel: RTL and testbench

Downstream stage of the IR camera position reader. It consumes raw 10-bit camera blob coordinates (1024x768 space) with a one-cycle strobe, rejects no-blob samples, and box-filters the last 2^AVG_LOG2 valid samples. It scales the result to 640x480 screen space and issues framebuffer pixel writes over a req/ack handshake. Writes happen only while the pen is down, and a write repeating the previous address is suppressed.

---
 rtl/graf_pkg.sv | 17 +
 rtl/box_filter.sv | 35 +++
 rtl/cam_pos_to_pixel.sv | 122 ++++++++++++
 tb/tb_cam_pos_to_pixel.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/graf_pkg.sv
// graf_pkg: shared constants, FSM state type and the camera-to-screen axis scaler.
package graf_pkg;
    localparam int CAM_X_MAX = 1023;
    localparam int CAM_Y_LIMIT = 768;
    localparam logic [9:0] NO_BLOB = 10'h3FF;
    localparam int SCALE_MUL = 5;
    localparam int SCALE_SHIFT = 3;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} state_t;

    // 5/8 maps 1024x768 onto 640x480; 13 bits hold 1023*5 without overflow
    function automatic logic [9:0] scale_axis(input logic [9:0] avg);
        logic [12:0] p;
        p = 13'(avg) * 13'(SCALE_MUL);
        return 10'(p >> SCALE_SHIFT);
    endfunction
endpackage

// File: rtl/box_filter.sv
// box_filter: running-sum moving average over the last 2^AVG_LOG2 pushed samples.
module box_filter #(
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  flush,
    input  logic [9:0]            din,
    output logic [9+AVG_LOG2:0]   sum,
    output logic                  full
);
    localparam int N = 1 << AVG_LOG2;
    localparam int SW = 10 + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;

    logic [9:0]    win [N];
    logic [FW-1:0] fill;

    assign full = fill == FW'(N);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            sum  <= '0;
            fill <= '0;
            for (int i = 0; i < N; i++) win[i] <= '0;
        end else if (push) begin
            // the oldest entry only leaves the sum once the window has filled
            sum  <= sum + SW'(din) - (full ? SW'(win[N-1]) : '0);
            fill <= full ? fill : fill + FW'(1);
            win[0] <= din;
            for (int i = 1; i < N; i++) win[i] <= win[i-1];
        end
    end
endmodule

// File: rtl/cam_pos_to_pixel.sv
// cam_pos_to_pixel: filters IR camera blob positions, scales them to screen space
// and issues deduplicated framebuffer pixel writes over a req/ack handshake.
module cam_pos_to_pixel
    import graf_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int LOST_COUNT = 3,
    parameter int SCR_W      = 640,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pos_valid,
    input  logic [9:0]         cam_x,
    input  logic [9:0]         cam_y,
    input  logic               pen_down,
    input  logic [COLOR_W-1:0] color,
    output logic               wr_req,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    input  logic               wr_ack,
    output logic [9:0]         cur_x,
    output logic [8:0]         cur_y,
    output logic               cur_valid,
    output logic               busy,
    output logic [7:0]         drop_count
);
    localparam int LW = $clog2(LOST_COUNT + 1);

    state_t             state;
    logic [LW-1:0]      lost, lost_nxt;
    logic [9:0]         samp_x, samp_y;
    logic [COLOR_W-1:0] samp_c;
    logic [ADDR_W-1:0]  last_addr, addr;
    logic               last_ok;
    logic [9+AVG_LOG2:0] sum_x, sum_y;
    logic               full_x, full_y, full;
    logic               invalid, push, flush;
    logic [9:0]         x_s, y_s;

    assign invalid  = cam_x == NO_BLOB || cam_y >= 10'(CAM_Y_LIMIT);
    assign lost_nxt = lost == LW'(LOST_COUNT) ? lost : lost + LW'(1);
    assign push     = state == ACCUM;
    assign flush    = state == IDLE && pos_valid && invalid && lost_nxt == LW'(LOST_COUNT);
    assign full     = full_x & full_y;
    assign x_s      = scale_axis(10'(sum_x >> AVG_LOG2));
    assign y_s      = scale_axis(10'(sum_y >> AVG_LOG2));
    assign addr     = ADDR_W'(y_s) * ADDR_W'(SCR_W) + ADDR_W'(x_s);
    assign busy     = state != IDLE;

    box_filter #(.AVG_LOG2(AVG_LOG2)) u_fx (
        .clk(clk), .reset(reset), .push(push), .flush(flush),
        .din(samp_x), .sum(sum_x), .full(full_x)
    );

    box_filter #(.AVG_LOG2(AVG_LOG2)) u_fy (
        .clk(clk), .reset(reset), .push(push), .flush(flush),
        .din(samp_y), .sum(sum_y), .full(full_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lost       <= '0;
            samp_x     <= '0;
            samp_y     <= '0;
            samp_c     <= '0;
            last_addr  <= '0;
            last_ok    <= 1'b0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_valid  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pos_valid && state != IDLE && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            case (state)
                IDLE: if (pos_valid) begin
                    if (invalid) begin
                        lost <= lost_nxt;
                        if (flush) begin
                            cur_valid <= 1'b0;
                            last_ok   <= 1'b0;
                        end
                    end else begin
                        lost   <= '0;
                        samp_x <= cam_x;
                        samp_y <= cam_y;
                        samp_c <= color;
                        state  <= ACCUM;
                    end
                end
                ACCUM: state <= SCALE;
                SCALE: begin
                    state <= IDLE;
                    if (full) begin
                        cur_x     <= x_s;
                        cur_y     <= 9'(y_s);
                        cur_valid <= 1'b1;
                        // repeated addresses are suppressed to spare framebuffer bandwidth
                        if (pen_down && (!last_ok || addr != last_addr)) begin
                            wr_addr <= addr;
                            wr_data <= samp_c;
                            wr_req  <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: if (wr_ack) begin
                    last_addr <= wr_addr;
                    last_ok   <= 1'b1;
                    wr_req    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cam_pos_to_pixel.sv
// tb_cam_pos_to_pixel: directed and randomized checks against a queue-based reference model.
module tb_cam_pos_to_pixel;
    logic        clk = 0, reset = 1, pos_valid = 0, pen_down = 0, wr_ack = 0;
    logic [9:0]  cam_x = 0, cam_y = 0;
    logic [3:0]  color = 0;
    logic        wr_req, cur_valid, busy;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic [9:0]  cur_x;
    logic [8:0]  cur_y;
    logic [7:0]  drop_count;

    cam_pos_to_pixel dut (
        .clk(clk), .reset(reset), .pos_valid(pos_valid), .cam_x(cam_x), .cam_y(cam_y),
        .pen_down(pen_down), .color(color), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .cur_x(cur_x), .cur_y(cur_y),
        .cur_valid(cur_valid), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int qx[$], qy[$];
    int lost = 0, la = 0, cx = 0, cy = 0;
    bit lv = 0, cv = 0;
    bit exp_wr, got_wr;
    int exp_addr, exp_data, got_addr, lat;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input int x, input int y, input bit pen, input int c);
        int ax, ay, sx, sy, a;
        exp_wr = 0;
        if (x == 1023 || y >= 768) begin
            if (lost < 3) lost++;
            if (lost == 3) begin
                qx.delete();
                qy.delete();
                cv = 0;
                lv = 0;
            end
        end else begin
            lost = 0;
            qx.push_back(x);
            qy.push_back(y);
            if (qx.size() > 4) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
            end
            if (qx.size() == 4) begin
                ax = qx.sum() / 4;
                ay = qy.sum() / 4;
                sx = ax * 5 / 8;
                sy = ay * 5 / 8;
                cx = sx;
                cy = sy;
                cv = 1;
                a = sy * 640 + sx;
                if (pen && (!lv || a != la)) begin
                    exp_wr = 1;
                    exp_addr = a;
                    exp_data = c;
                    la = a;
                    lv = 1;
                end
            end
        end
    endtask

    task automatic send(input int x, input int y, input bit pen, input int c);
        cam_x = 10'(x);
        cam_y = 10'(y);
        pen_down = pen;
        color = 4'(c);
        pos_valid = 1;
        step();
        pos_valid = 0;
        model(x, y, pen, c);
        got_wr = 0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            if (wr_req) begin
                got_wr = 1;
                lat = n;
                got_addr = int'(wr_addr);
                step();
                check("addr_hold", wr_addr, got_addr);
                wr_ack = 1;
                step();
                wr_ack = 0;
                break;
            end
            if (!busy) break;
            step();
        end
        check("wr", got_wr, exp_wr);
        if (got_wr && exp_wr) begin
            check("wr_addr", got_addr, exp_addr);
            check("wr_data", wr_data, exp_data);
            check("latency", lat, 3);
        end
        check("req_low", wr_req, 0);
        check("idle", busy, 0);
        check("cur_x", cur_x, cx);
        check("cur_y", cur_y, cy);
        check("cur_valid", cur_valid, cv);
        check("drop0", drop_count, 0);
    endtask

    initial begin
        int x, y, r, px, py;
        #1 reset = 0;
        step();
        step();
        reset = 1;
        check("rst_req", wr_req, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_cx", cur_x, 0);
        check("rst_cy", cur_y, 0);
        check("rst_cv", cur_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);

        for (int i = 0; i < 4; i++) begin
            send(100, 200, 1, 'hA);
            check("t1_wr", got_wr, i == 3);
        end
        check("t1_cx", cur_x, 62);
        check("t1_cy", cur_y, 125);
        check("t1_addr", got_addr, 80062);

        send(100, 200, 1, 'hA);
        check("t3_dup", got_wr, 0);
        send(108, 200, 1, 'hA);
        check("t3_wr", got_wr, 1);
        check("t3_addr", got_addr, 80063);

        for (int i = 0; i < 4; i++) send(1022, 767, 1, 3);
        check("t2_cx", cur_x, 638);
        check("t2_cy", cur_y, 479);
        check("t2_addr", got_addr, 307198);

        for (int i = 0; i < 3; i++) send(1023, 1023, 1, 3);
        check("t4_cv", cur_valid, 0);
        for (int i = 0; i < 4; i++) begin
            send(1022, 767, 1, 3);
            check("t4_wr", got_wr, i == 3);
        end

        send(300, 300, 0, 7);
        check("t5_wr", got_wr, 0);

        px = 500;
        py = 300;
        repeat (150) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                x = 1023;
                y = $urandom_range(0, 1023);
            end else if (r == 1) begin
                x = $urandom_range(0, 1022);
                y = $urandom_range(768, 1023);
            end else if (r <= 3) begin
                x = px;
                y = py;
            end else begin
                x = $urandom_range(0, 1022);
                y = $urandom_range(0, 767);
                px = x;
                py = y;
            end
            send(x, y, $urandom_range(0, 3) != 0, $urandom_range(0, 15));
        end

        for (int i = 0; i < 3; i++) send(1023, 0, 1, 0);
        for (int i = 0; i < 3; i++) send(400, 400, 1, 5);
        cam_x = 400;
        cam_y = 400;
        pen_down = 1;
        color = 5;
        pos_valid = 1;
        step();
        pos_valid = 0;
        step();
        step();
        check("t6_req", wr_req, 1);
        check("t6_addr", wr_addr, 160250);
        repeat (3) begin
            pos_valid = 1;
            step();
            pos_valid = 0;
            step();
        end
        check("t6_drop", drop_count, 3);
        check("t6_hold", wr_addr, 160250);
        check("t6_req_held", wr_req, 1);
        #2 reset = 0;
        #1;
        check("t6_rst_req", wr_req, 0);
        check("t6_rst_drop", drop_count, 0);
        check("t6_rst_cv", cur_valid, 0);
        check("t6_rst_busy", busy, 0);
        step();
        reset = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
